// File: rtl/mem_b_writer_pkg.sv
// ---------------------------------------------------------------------------
// mem_b_writer_pkg
// Shared definitions for the memory-to-memory transfer path: default data and
// address widths (common to the memory-A reader, the subtracter and the
// memory-B writer) and the writer FSM state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mem_b_writer_pkg;

   localparam int DATA_W_DEFAULT = 8;
   localparam int ADDR_W_DEFAULT = 4;

   // Writer FSM states. The encoding is fixed so that state values seen on a
   // debug bus or in a waveform mean the same thing in every block of the path.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      DONE  = 2'b10
   } wrState_e;

   // A transfer counts as in progress from the first write cycle up to and
   // including the single completion cycle.
   function automatic logic isBusyState(input wrState_e s);
      return (s == WRITE) || (s == DONE);
   endfunction

endpackage

// File: rtl/mem_b_addr_counter.sv
// ---------------------------------------------------------------------------
// mem_b_addr_counter
// Loadable wrapping address pointer plus word counter with a terminal-count
// flag. Usable by any controller that walks a block of consecutive memory
// locations (memory-B writer, memory-A reader).
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_i      start a new block: pointer <= baseAddr_i, count <= 0,
//               length <= length_i
//   clear_i     zero the count and stored length without moving the pointer
//   advance_i   one word handled: pointer and count step by one
//   baseAddr_i  first address of the block
//   length_i    number of words in the block (0 .. 2**ADDR_W)
//   ptr_o       current address pointer (wraps modulo 2**ADDR_W)
//   count_o     words handled since the last load/clear
//   lastWord_o  the word at the current pointer is the final one of the block
// ---------------------------------------------------------------------------
module mem_b_addr_counter
   import mem_b_writer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic              advance_i,
   input  logic [ADDR_W-1:0] baseAddr_i,
   input  logic [ADDR_W:0]   length_i,
   output logic [ADDR_W-1:0] ptr_o,
   output logic [ADDR_W:0]   count_o,
   output logic              lastWord_o
);

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   len_q,   len_d;

   // Next-state selection. Load has priority so a new block always starts
   // cleanly; the pointer is ADDR_W bits wide so it wraps naturally past the
   // top of memory. The count is one bit wider so a full-memory block of
   // 2**ADDR_W words can be represented.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      len_d   = len_q;
      if (load_i) begin
         ptr_d   = baseAddr_i;
         count_d = '0;
         len_d   = length_i;
      end else if (clear_i) begin
         count_d = '0;
         len_d   = '0;
      end else if (advance_i) begin
         ptr_d   = ptr_q + PTR_ONE;
         count_d = count_q + CNT_ONE;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         len_q   <= len_d;
      end
   end

   // The word being handled now is the last one when one more step makes the
   // count reach the stored length. This is a look-ahead flag so the owning
   // FSM can leave its working state on the same edge that takes that word.
   assign lastWord_o = ((count_q + CNT_ONE) == len_q);

   assign ptr_o   = ptr_q;
   assign count_o = count_q;

endmodule

// File: rtl/mem_b_writer.sv
// ---------------------------------------------------------------------------
// mem_b_writer
// Write-side controller of the memory-to-memory transfer path. Takes the
// stream of subtracter results over a valid/ready handshake and writes them
// to consecutive (wrapping) addresses of memory B, starting at a programmable
// base, for a programmable word count. Reports busy, a done pulse, the number
// of words taken and a sticky misuse flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle transfer request; base_addr and length sampled with it
//   base_addr  first write address
//   length     words to write (0 .. 2**ADDR_W)
//   din_valid  upstream result valid
//   din        upstream result (SUBOut)
//   din_ready  result can be taken this cycle
//   mem_we     memory-B write enable (registered)
//   mem_addr   memory-B write address (registered)
//   mem_din    memory-B write data (registered)
//   busy       transfer in progress (write and completion cycles)
//   done       one-cycle completion pulse
//   wr_count   words taken in the current or last transfer
//   err        sticky misuse flag (start while busy)
// ---------------------------------------------------------------------------
module mem_b_writer
   import mem_b_writer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              din_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count,
   output logic              err
);

   wrState_e          state_q, state_d;
   logic              err_q, err_d;
   logic              memWe_q, memWe_d;
   logic [ADDR_W-1:0] memAddr_q, memAddr_d;
   logic [DATA_W-1:0] memDin_q, memDin_d;

   logic              accept;
   logic              lengthZero;
   logic              loadPtr;
   logic              clearCount;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   count;
   logic              lastWord;

   assign lengthZero = (length == '0);
   assign accept     = din_valid & din_ready;

   // Pointer and word counter. They are loaded by an accepted start and step
   // once per handshake, so the pointer always holds the address for the word
   // that is being offered right now.
   mem_b_addr_counter #(
      .ADDR_W (ADDR_W)
   ) u_addrCounter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (loadPtr),
      .clear_i    (clearCount),
      .advance_i  (accept),
      .baseAddr_i (base_addr),
      .length_i   (length),
      .ptr_o      (ptr),
      .count_o    (count),
      .lastWord_o (lastWord)
   );

   // Next-state and control decode. A start is only honoured from IDLE; an
   // empty transfer skips straight to the completion cycle so the requester
   // still sees a done pulse. Any start seen while a transfer is running or
   // completing is dropped and flagged, never queued.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      loadPtr    = 1'b0;
      clearCount = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (lengthZero) begin
                  clearCount = 1'b1;
                  state_d    = DONE;
               end else begin
                  loadPtr = 1'b1;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (start) begin
               err_d = 1'b1;
            end
            if (accept && lastWord) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               err_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Memory-B port staging. Every accepted word is presented to the memory in
   // the following cycle; in cycles without a handshake the enable drops while
   // address and data keep their last values to avoid needless toggling.
   always_comb begin
      memWe_d   = accept;
      memAddr_d = memAddr_q;
      memDin_d  = memDin_q;
      if (accept) begin
         memAddr_d = ptr;
         memDin_d  = din;
      end
   end

   // All control and memory-port registers clear asynchronously so that a
   // reset in the middle of a transfer stops writes at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         err_q     <= 1'b0;
         memWe_q   <= 1'b0;
         memAddr_q <= '0;
         memDin_q  <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         memWe_q   <= memWe_d;
         memAddr_q <= memAddr_d;
         memDin_q  <= memDin_d;
      end
   end

   // Status outputs are decoded straight from the state register, so they
   // follow reset immediately and never depend on the current inputs.
   assign din_ready = (state_q == WRITE);
   assign busy      = isBusyState(state_q);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign wr_count  = count;
   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_din   = memDin_q;

endmodule
